ppg_dual_fir: RTL and testbench
===============================

Name: ppg_dual_fir

Overview:
- Downstream stage of the LED/AFE controller.
- Consumes the demultiplexed IR_ADC_Value / RED_ADC_Value samples and the CLK_Filter toggle the controller produces in its oscillate phase.
- Low-pass filters both channels with one shared 16-tap FIR (time-serial MAC, both channels computed in parallel) and presents filtered 8-bit samples, with a valid pulse, to the SpO2/heart-rate stage.

Parameters:
- NTAPS, 16, filter length (power of 2; circular buffer depth).
- EDGE_DIV, 10, one sample pair is accepted every EDGE_DIV rising edges of CLK_Filter.
- SHIFT, 8, right shift applied to the accumulator before saturation.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- CLK_Filter  in  1  filter sample toggle from controller; synchronous to CLK.
- IR_ADC_Value  in  8  latest IR sample (unsigned).
- RED_ADC_Value  in  8  latest RED sample (unsigned).
- Coef_Wr  in  1  coefficient write strobe.
- Coef_Addr  in  4  tap index to write.
- Coef_Data  in  8  unsigned coefficient value.
- IR_Filt_Out  out  8  filtered IR sample.
- RED_Filt_Out  out  8  filtered RED sample.
- Filt_Valid  out  1  one-cycle pulse: new filtered pair on outputs.
- Busy  out  1  high while a MAC pass is in progress.
- Overrun  out  1  sticky: an accepted edge arrived while Busy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0;
  - both sample buffers 0, write pointer 0, edge counter 0, tap index 0, accumulators 0;
  - all coefficients 16 (sum 256, so default is a 16-point moving average);
  - CLK_Filter edge register 0;
  - FSM to IDLE.
  - Reset asserted mid-pass aborts the pass; no Filt_Valid follows.
- Edge detection:
  - CLK_Filter is registered each cycle; a rising edge is cur=1, prev=0.
  - Edge counter counts 0..EDGE_DIV-1 on every rising edge, regardless of state.
  - An edge is accepted when the counter equals 0, so the first edge after reset is accepted, then every EDGE_DIV-th.
- FSM:
  - IDLE: on an accepted edge (cycle E):
    - write both inputs to buffer[wr_ptr];
    - the written slot becomes newest, wr_ptr increments modulo NTAPS;
    - clear both accumulators, tap k=0, go to MAC, Busy=1 from E+1.
  - MAC: cycles E+1..E+NTAPS, one tap per cycle on each channel:
    - acc += coef[k] * buf[newest - k mod NTAPS];
    - k=0 is the newest sample;
    - after k=NTAPS-1, go to OUT.
  - OUT (E+NTAPS+1):
    - each output = min(acc >> SHIFT, 255);
    - outputs and Filt_Valid=1 are visible at cycle E+NTAPS+2 (E+18 at defaults);
    - Filt_Valid lasts exactly one cycle;
    - Busy drops in the same cycle Filt_Valid rises;
    - FSM returns to IDLE.
  - An edge accepted in that same cycle starts a new pass.
- Widths:
  - product is 16 bits;
  - accumulator is 20 bits (max 255*255*16 = 1,040,400 fits, no wrap);
  - outputs saturate at 255;
  - no signed arithmetic.
- Overrun:
  - An accepted edge while in MAC or OUT is dropped: no buffer write, pass unaffected.
  - Overrun is set and held until reset.
- Coefficient writes:
  - Coef_Wr in IDLE with no accepted edge that cycle: coef[Coef_Addr] <= Coef_Data, effective from the next pass.
  - Coef_Wr during MAC/OUT, or in the same cycle as an accepted edge, is ignored.
- Output stability: outputs hold their last value between Filt_Valid pulses.

Test Plan:
1. Reset, default coefs; toggle CLK_Filter every CLK; IR=100, RED=200 constant. The first accepted edge yields IR_Filt_Out=6, RED_Filt_Out=12 with Filt_Valid 18 clocks after the edge. Pass n yields floor(100*n/16) and floor(200*n/16); pass 16 onward gives exactly 100/200. Filt_Valid spacing is 20 CLK.
2. In IDLE write coef[0]=255 and coef[1..15]=0; feed IR=RED=200. Outputs are 199 (floor(200*255/256)). With IR=0 on the next sample, IR output is 0 (no history leakage).
3. All coefs=255, inputs 255 for 16 passes: outputs saturate at 255 with no wrap; partial sums at pass 1 give 254.
4. EDGE_DIV overridden to 1, CLK_Filter rising every 4 CLK: Overrun goes high during the first pass. Dropped samples do not advance wr_ptr. Filt_Valid occurs every 20 CLK (every 5th edge).
5. Assert rst_n low at E+8 mid-pass, release: all outputs 0, no Filt_Valid. The next accepted edge is the first rising edge after release. Coefficients are back to 16.
6. Coef_Wr (addr 0, data 0) asserted during MAC, and again coincident with an accepted edge: both ignored, and moving-average results are unchanged versus scenario 1.

Source files
------------

// File: rtl/ppg_dual_fir.sv
// Dual-channel (IR/RED) 16-tap low-pass FIR with a shared coefficient set.
// One time-serial MAC pass per accepted CLK_Filter edge; both channels accumulate in parallel.
module ppg_dual_fir #(
  parameter int NTAPS    = 16,
  parameter int EDGE_DIV = 10,
  parameter int SHIFT    = 8
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       CLK_Filter,
  input  logic [7:0] IR_ADC_Value,
  input  logic [7:0] RED_ADC_Value,
  input  logic       Coef_Wr,
  input  logic [3:0] Coef_Addr,
  input  logic [7:0] Coef_Data,
  output logic [7:0] IR_Filt_Out,
  output logic [7:0] RED_Filt_Out,
  output logic       Filt_Valid,
  output logic       Busy,
  output logic       Overrun
);

  localparam int AW    = $clog2(NTAPS);
  localparam int CW    = (EDGE_DIV > 1) ? $clog2(EDGE_DIV) : 1;
  localparam int ACC_W = 20;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t           state_reg;
  logic             cf_prev_reg;
  logic [CW-1:0]    edge_cnt_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    newest_reg;
  logic [AW-1:0]    tap_reg;
  logic [ACC_W-1:0] acc_ir_reg;
  logic [ACC_W-1:0] acc_red_reg;

  logic [7:0] coef_arr [NTAPS];
  logic [7:0] ir_arr   [NTAPS];
  logic [7:0] red_arr  [NTAPS];

  logic          rise;
  logic          accept;
  logic          start_pass;
  logic          coef_we;
  logic [AW-1:0] rd_idx;
  logic [15:0]   prod_ir;
  logic [15:0]   prod_red;

  assign rise       = CLK_Filter & ~cf_prev_reg;
  assign accept     = rise && (edge_cnt_reg == '0);
  assign start_pass = accept && (state_reg == IDLE);
  // Coefficients only change between passes so a pass never sees a mixed set.
  assign coef_we    = Coef_Wr && (state_reg == IDLE) && !accept;
  assign rd_idx     = newest_reg - tap_reg;
  assign prod_ir    = {8'd0, coef_arr[tap_reg]} * {8'd0, ir_arr[rd_idx]};
  assign prod_red   = {8'd0, coef_arr[tap_reg]} * {8'd0, red_arr[rd_idx]};

  genvar gi;
  generate
    for (gi = 0; gi < NTAPS; gi++) begin : g_tap
      logic [7:0] coef_reg;
      logic [7:0] ir_reg;
      logic [7:0] red_reg;

      always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
          coef_reg <= 8'd16;
          ir_reg   <= '0;
          red_reg  <= '0;
        end else begin
          if (coef_we && (Coef_Addr == 4'(gi)))
            coef_reg <= Coef_Data;
          if (start_pass && (wr_ptr_reg == AW'(gi))) begin
            ir_reg  <= IR_ADC_Value;
            red_reg <= RED_ADC_Value;
          end
        end
      end

      assign coef_arr[gi] = coef_reg;
      assign ir_arr[gi]   = ir_reg;
      assign red_arr[gi]  = red_reg;
    end
  endgenerate

  function automatic logic [7:0] sat(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] s;
    s = a >> SHIFT;
    return (s > ACC_W'(255)) ? 8'hFF : s[7:0];
  endfunction

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cf_prev_reg  <= 1'b0;
      edge_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      newest_reg   <= '0;
      tap_reg      <= '0;
      acc_ir_reg   <= '0;
      acc_red_reg  <= '0;
      IR_Filt_Out  <= '0;
      RED_Filt_Out <= '0;
      Filt_Valid   <= 1'b0;
      Busy         <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      cf_prev_reg <= CLK_Filter;
      Filt_Valid  <= 1'b0;
      if (rise)
        edge_cnt_reg <= (edge_cnt_reg == CW'(EDGE_DIV - 1)) ? '0 : edge_cnt_reg + CW'(1);
      // Edges accepted mid-pass are dropped, never queued.
      if (accept && (state_reg != IDLE))
        Overrun <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (accept) begin
            newest_reg  <= wr_ptr_reg;
            wr_ptr_reg  <= wr_ptr_reg + AW'(1);
            acc_ir_reg  <= '0;
            acc_red_reg <= '0;
            tap_reg     <= '0;
            Busy        <= 1'b1;
            state_reg   <= MAC;
          end
        end
        MAC: begin
          acc_ir_reg  <= acc_ir_reg + {4'd0, prod_ir};
          acc_red_reg <= acc_red_reg + {4'd0, prod_red};
          tap_reg     <= tap_reg + AW'(1);
          if (tap_reg == AW'(NTAPS - 1))
            state_reg <= OUT;
        end
        OUT: begin
          IR_Filt_Out  <= sat(acc_ir_reg);
          RED_Filt_Out <= sat(acc_red_reg);
          Filt_Valid   <= 1'b1;
          Busy         <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppg_dual_fir.sv
// Bench for ppg_dual_fir: two instances (EDGE_DIV 10 and 1) checked every cycle
// against a sample-history/timestamp reference model.
module tb_ppg_dual_fir;

  localparam int NT = 16;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       cf0 = 1'b0;
  logic       cf1 = 1'b0;
  logic [7:0] ir_in = '0;
  logic [7:0] red_in = '0;
  logic       coef_wr = 1'b0;
  logic [3:0] coef_addr = '0;
  logic [7:0] coef_data = '0;

  logic [7:0] ir_out  [2];
  logic [7:0] red_out [2];
  logic       valid   [2];
  logic       busy    [2];
  logic       ovr     [2];

  always #5 CLK = ~CLK;

  ppg_dual_fir dut0 (
    .CLK(CLK), .rst_n(rst_n), .CLK_Filter(cf0),
    .IR_ADC_Value(ir_in), .RED_ADC_Value(red_in),
    .Coef_Wr(coef_wr), .Coef_Addr(coef_addr), .Coef_Data(coef_data),
    .IR_Filt_Out(ir_out[0]), .RED_Filt_Out(red_out[0]),
    .Filt_Valid(valid[0]), .Busy(busy[0]), .Overrun(ovr[0])
  );

  ppg_dual_fir #(.EDGE_DIV(1)) dut1 (
    .CLK(CLK), .rst_n(rst_n), .CLK_Filter(cf1),
    .IR_ADC_Value(ir_in), .RED_ADC_Value(red_in),
    .Coef_Wr(coef_wr), .Coef_Addr(coef_addr), .Coef_Data(coef_data),
    .IR_Filt_Out(ir_out[1]), .RED_Filt_Out(red_out[1]),
    .Filt_Valid(valid[1]), .Busy(busy[1]), .Overrun(ovr[1])
  );

  // Reference model state, one set per instance
  int     div_m [2] = '{10, 1};
  int     coef_m [2][NT];
  int     hir [2][NT];
  int     hred [2][NT];
  int     edges [2];
  bit     prev_cf [2];
  longint start_m [2];
  bit     ovr_m [2];
  int     exp_ir [2];
  int     exp_red [2];
  int     pend_ir [2];
  int     pend_red [2];
  longint cyc = 0;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int filt(int i, bit use_red);
    int s;
    s = 0;
    for (int k = 0; k < NT; k++)
      s += coef_m[i][k] * (use_red ? hred[i][k] : hir[i][k]);
    s = s >> 8;
    return (s > 255) ? 255 : s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < NT; k++) begin
        coef_m[i][k] = 16;
        hir[i][k] = 0;
        hred[i][k] = 0;
      end
      edges[i] = 0;
      prev_cf[i] = 1'b0;
      start_m[i] = -1000;
      ovr_m[i] = 1'b0;
      exp_ir[i] = 0;
      exp_red[i] = 0;
    end
  endtask

  // Advance one clock: update the model from the current inputs, then check both DUTs.
  task automatic step();
    bit busy_now, rise, acc, vexp;
    bit cfv [2];
    cfv[0] = cf0;
    cfv[1] = cf1;
    for (int i = 0; i < 2; i++) begin
      busy_now = (cyc > start_m[i]) && (cyc <= start_m[i] + 17);
      rise = cfv[i] && !prev_cf[i];
      prev_cf[i] = cfv[i];
      acc = rise && ((edges[i] % div_m[i]) == 0);
      if (rise) edges[i]++;
      if (acc && busy_now) begin
        ovr_m[i] = 1'b1;
      end else if (acc) begin
        for (int k = NT - 1; k > 0; k--) begin
          hir[i][k] = hir[i][k-1];
          hred[i][k] = hred[i][k-1];
        end
        hir[i][0] = ir_in;
        hred[i][0] = red_in;
        pend_ir[i] = filt(i, 1'b0);
        pend_red[i] = filt(i, 1'b1);
        start_m[i] = cyc;
      end else if (coef_wr && !busy_now) begin
        coef_m[i][coef_addr] = coef_data;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      vexp = (cyc == start_m[i] + 18);
      if (vexp) begin
        exp_ir[i] = pend_ir[i];
        exp_red[i] = pend_red[i];
      end
      chk($sformatf("valid%0d@%0d", i, cyc), valid[i], vexp);
      chk($sformatf("busy%0d@%0d", i, cyc), busy[i], (cyc > start_m[i]) && (cyc <= start_m[i] + 17));
      chk($sformatf("ir%0d@%0d", i, cyc), ir_out[i], exp_ir[i]);
      chk($sformatf("red%0d@%0d", i, cyc), red_out[i], exp_red[i]);
      chk($sformatf("ovr%0d@%0d", i, cyc), ovr[i], ovr_m[i]);
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_ir%0d", tag, i), ir_out[i], 0);
      chk($sformatf("%s_red%0d", tag, i), red_out[i], 0);
      chk($sformatf("%s_valid%0d", tag, i), valid[i], 0);
      chk($sformatf("%s_busy%0d", tag, i), busy[i], 0);
      chk($sformatf("%s_ovr%0d", tag, i), ovr[i], 0);
    end
    model_reset();
    repeat (2) @(posedge CLK);
    cyc += 2;
    #2 rst_n = 1'b1;
  endtask

  task automatic write_coefs(input int c0, input int crest);
    for (int a = 0; a < NT; a++) begin
      coef_wr = 1'b1;
      coef_addr = 4'(a);
      coef_data = 8'((a == 0) ? c0 : crest);
      step();
    end
    coef_wr = 1'b0;
  endtask

  // Constant inputs, CLK_Filter toggling every clock; optional coefficient writes
  // that must be ignored (at the accepted edge and mid-MAC).
  task automatic run_avg(input bit with_wr, input string tag);
    int n;
    ir_in = 8'd100;
    red_in = 8'd200;
    for (int j = 0; j < 17 * 20; j++) begin
      cf0 = ~cf0;
      coef_wr = with_wr && ((j % 20) == 0 || (j % 20) == 5);
      coef_addr = 4'd0;
      coef_data = 8'd0;
      step();
      if ((j % 20) == 17) begin
        n = (j / 20) + 1;
        if (n > 16) n = 16;
        chk($sformatf("%s_ir_pass%0d", tag, j / 20 + 1), ir_out[0], (100 * n) / 16);
        chk($sformatf("%s_red_pass%0d", tag, j / 20 + 1), red_out[0], (200 * n) / 16);
      end
    end
    coef_wr = 1'b0;
  endtask

  initial begin
    int vcnt;
    longint old_start;

    #1;
    do_reset("por");

    // Moving average ramp with default coefficients
    run_avg(1'b0, "avg");

    // Single-tap filter: coef[0]=255, others 0
    cf0 = 1'b0;
    do_reset("rst2");
    write_coefs(255, 0);
    ir_in = 8'd200;
    red_in = 8'd200;
    for (int j = 0; j < 20; j++) begin cf0 = ~cf0; step(); end
    chk("tap0_ir", ir_out[0], 199);
    chk("tap0_red", red_out[0], 199);
    ir_in = 8'd0;
    for (int j = 0; j < 20; j++) begin cf0 = ~cf0; step(); end
    chk("tap0_ir_zero", ir_out[0], 0);
    chk("tap0_red_hold", red_out[0], 199);

    // Saturation with all coefficients at 255
    cf0 = 1'b0;
    do_reset("rst3");
    write_coefs(255, 255);
    ir_in = 8'd255;
    red_in = 8'd255;
    for (int j = 0; j < 17 * 20; j++) begin
      cf0 = ~cf0;
      step();
      if (j == 17) chk("sat_pass1", ir_out[0], 254);
    end
    chk("sat_final_ir", ir_out[0], 255);
    chk("sat_final_red", red_out[0], 255);

    // Reset mid-pass: start a pass, assert reset at E+8
    ir_in = 8'd100;
    red_in = 8'd200;
    old_start = start_m[0];
    for (int j = 0; j < 40 && start_m[0] == old_start; j++) begin cf0 = ~cf0; step(); end
    chk("midrst_started", start_m[0] != old_start, 1);
    for (int j = 0; j < 7; j++) begin cf0 = ~cf0; step(); end
    do_reset("midrst");
    for (int j = 0; j < 20; j++) begin cf0 = ~cf0; step(); end
    chk("midrst_ir_coef16", ir_out[0], 6);
    chk("midrst_red_coef16", red_out[0], 12);

    // Ignored coefficient writes during MAC and at the accepted edge
    cf0 = 1'b0;
    do_reset("rst6");
    run_avg(1'b1, "ignwr");

    // EDGE_DIV=1 instance, rising edge every 4 clocks: overrun and drops
    cf0 = 1'b0;
    cf1 = 1'b0;
    do_reset("rst4");
    vcnt = 0;
    for (int j = 0; j < 100; j++) begin
      cf1 = ((j % 4) < 2);
      ir_in = 8'($urandom_range(0, 255));
      red_in = 8'($urandom_range(0, 255));
      step();
      if (valid[1]) vcnt++;
    end
    chk("div1_valid_count", vcnt, 5);
    chk("div1_overrun", ovr[1], 1);

    // Randomized traffic on both instances
    for (int j = 0; j < 2000; j++) begin
      cf0 = 1'($urandom_range(0, 1));
      cf1 = 1'($urandom_range(0, 1));
      ir_in = 8'($urandom_range(0, 255));
      red_in = 8'($urandom_range(0, 255));
      coef_wr = ($urandom_range(0, 7) == 0);
      coef_addr = 4'($urandom_range(0, 15));
      coef_data = 8'($urandom_range(0, 255));
      step();
    end
    coef_wr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
